shared_reg_write_arbiter: RTL and testbench



---
 rtl/shared_reg_pkg.sv | 26 ++
 rtl/shared_reg_write_arbiter_if.sv | 32 +++
 rtl/rr_prio2.sv | 40 ++++
 rtl/shared_reg_write_arbiter.sv | 84 ++++++++
 tb/tb_shared_reg_write_arbiter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/shared_reg_pkg.sv
// shared_reg_pkg
// Shared definitions for the two-writer shared register arbiter.
//   W      : default width of the shared register (bit index ascending [0:W-1])
//   CNT_W  : default width of the saturating conflict counter
//   prio_e : round-robin priority holder (writer A or writer B)
//   merge  : applies one bit-masked write to a register value
package shared_reg_pkg;

  localparam int W     = 8;
  localparam int CNT_W = 8;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  // Bits with a set mask bit take the write data; all other bits keep cur.
  function automatic logic [0:W-1] merge(
    input logic [0:W-1] cur,
    input logic [0:W-1] mask,
    input logic [0:W-1] data
  );
    merge = (cur & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/shared_reg_write_arbiter_if.sv
// shared_reg_write_arbiter_if
// One masked-write request channel into the shared register arbiter.
// Instantiated once per writer.
//   valid : writer requests a write this cycle
//   mask  : bits the writer wants to write, [0:W-1]
//   data  : write data, [0:W-1]
//   gnt   : the write commits on the next rising edge (combinational)
// Modports: master = the writer, slave = the arbiter.
interface shared_reg_write_arbiter_if #(
  parameter int W = shared_reg_pkg::W
);

  logic         valid;
  logic [0:W-1] mask;
  logic [0:W-1] data;
  logic         gnt;

  modport master (
    output valid,
    output mask,
    output data,
    input  gnt
  );

  modport slave (
    input  valid,
    input  mask,
    input  data,
    output gnt
  );

endinterface

// File: rtl/rr_prio2.sv
// rr_prio2
// One-bit round-robin priority pointer for two requesters. The holder
// flips to the other requester on every conflict cycle, so whoever lost a
// conflict is guaranteed to win the next one.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset, returns priority to A
//   conflict : both writers requested overlapping bits this cycle
//   prio_b   : current priority holder (0 = A, 1 = B)
module rr_prio2
  import shared_reg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic conflict,
  output logic prio_b
);

  prio_e state;
  prio_e state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PRIO_A;
    end else begin
      state <= state_next;
    end
  end

  // The winner of a conflict is always the current holder, so flipping
  // hands priority to the loser.
  always_comb begin
    state_next = state;
    if (conflict) begin
      state_next = (state == PRIO_A) ? PRIO_B : PRIO_A;
    end
  end

  assign prio_b = (state == PRIO_B);

endmodule

// File: rtl/shared_reg_write_arbiter.sv
// shared_reg_write_arbiter
// Single owner of a W-bit register that two writers update with bit-masked
// writes. Non-overlapping writes merge in the same cycle; overlapping
// writes are resolved by a round-robin priority and the loser waits.
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset
//   a, b         : writer request channels (valid/mask/data in, gnt out)
//   q            : shared register, [0:W-1]
//   upd          : one-cycle pulse, high after a commit that changed q
//   conflict     : both valid with overlapping masks (combinational)
//   prio_b       : current priority holder (0 = A, 1 = B)
//   conflict_cnt : saturating count of conflict cycles
module shared_reg_write_arbiter
  import shared_reg_pkg::*;
#(
  parameter int W_P     = shared_reg_pkg::W,
  parameter int CNT_W_P = shared_reg_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  shared_reg_write_arbiter_if.slave     a,
  shared_reg_write_arbiter_if.slave     b,
  output logic [0:W_P-1]                q,
  output logic                          upd,
  output logic                          conflict,
  output logic                          prio_b,
  output logic [CNT_W_P-1:0]            conflict_cnt
);

  logic [0:W_P-1] q_next;
  logic           a_gnt;
  logic           b_gnt;

  assign conflict = a.valid && b.valid && ((a.mask & b.mask) != '0);

  rr_prio2 u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .conflict (conflict),
    .prio_b   (prio_b)
  );

  // Without overlap every valid writer is granted; with overlap only the
  // priority holder is. Grants are suppressed while reset is asserted so no
  // writer believes its request was taken by a register being cleared.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      a_gnt = a.valid && (!conflict || !prio_b);
      b_gnt = b.valid && (!conflict ||  prio_b);
    end
  end

  assign a.gnt = a_gnt;
  assign b.gnt = b_gnt;

  // Granted writers never share a bit, so applying them in sequence is
  // equivalent to a per-bit select.
  always_comb begin
    q_next = q;
    if (a_gnt) begin
      q_next = merge(q_next, a.mask, a.data);
    end
    if (b_gnt) begin
      q_next = merge(q_next, b.mask, b.data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q            <= '0;
      upd          <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      q   <= q_next;
      upd <= (q_next != q);
      if (conflict && (conflict_cnt != {CNT_W_P{1'b1}})) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_write_arbiter.sv
// tb_shared_reg_write_arbiter
// Directed self-checking bench for shared_reg_write_arbiter. Inputs change
// on the falling edge; combinational outputs are sampled 1 time unit after
// that, registered outputs 1 time unit after the rising edge.
module tb_shared_reg_write_arbiter;

  logic       clk;
  logic       rst_n;
  logic [0:7] q;
  logic       upd;
  logic       conflict;
  logic       prio_b;
  logic [7:0] conflict_cnt;

  int checkCount;
  int passCount;

  shared_reg_write_arbiter_if #(.W(8)) a_if ();
  shared_reg_write_arbiter_if #(.W(8)) b_if ();

  shared_reg_write_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a_if.slave),
    .b            (b_if.slave),
    .q            (q),
    .upd          (upd),
    .conflict     (conflict),
    .prio_b       (prio_b),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive both writer channels on the falling edge, then settle.
  task automatic applyStimulus(
    input logic av, input logic [7:0] am, input logic [7:0] ad,
    input logic bv, input logic [7:0] bm, input logic [7:0] bd
  );
    @(negedge clk);
    a_if.valid = av;
    a_if.mask  = am;
    a_if.data  = ad;
    b_if.valid = bv;
    b_if.mask  = bm;
    b_if.data  = bd;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    a_if.valid = 1'b0;
    a_if.mask  = '0;
    a_if.data  = '0;
    b_if.valid = 1'b0;
    b_if.mask  = '0;
    b_if.data  = '0;

    // Reset with a pending request: grants forced low, state cleared.
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h0F, 8'h0F);
    checkOutput("rst_a_gnt", 32'(a_if.gnt), 32'h0);
    checkOutput("rst_b_gnt", 32'(b_if.gnt), 32'h0);
    stepClock();
    stepClock();
    checkOutput("rst_q", 32'(q), 32'h00);
    checkOutput("rst_upd", 32'(upd), 32'h0);
    checkOutput("rst_prio", 32'(prio_b), 32'h0);
    checkOutput("rst_cnt", 32'(conflict_cnt), 32'h0);

    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    stepClock();

    // A alone, mask F0 data A5 -> q A0.
    applyStimulus(1'b1, 8'hF0, 8'hA5, 1'b0, 8'h00, 8'h00);
    checkOutput("a_only_gnt", 32'(a_if.gnt), 32'h1);
    checkOutput("a_only_bgnt", 32'(b_if.gnt), 32'h0);
    stepClock();
    checkOutput("a_only_q", 32'(q), 32'hA0);
    checkOutput("a_only_upd", 32'(upd), 32'h1);

    // Disjoint masks merge in one cycle.
    applyStimulus(1'b1, 8'hF0, 8'hFF, 1'b1, 8'h0F, 8'h0F);
    checkOutput("merge_a_gnt", 32'(a_if.gnt), 32'h1);
    checkOutput("merge_b_gnt", 32'(b_if.gnt), 32'h1);
    checkOutput("merge_conflict", 32'(conflict), 32'h0);
    stepClock();
    checkOutput("merge_q", 32'(q), 32'hFF);
    checkOutput("merge_cnt", 32'(conflict_cnt), 32'h0);

    // Overlap from prio A: A wins (q FF -> 07), then B alone (q -> 1F).
    applyStimulus(1'b1, 8'hF8, 8'h00, 1'b1, 8'h1F, 8'h1F);
    checkOutput("ovl1_conflict", 32'(conflict), 32'h1);
    checkOutput("ovl1_a_gnt", 32'(a_if.gnt), 32'h1);
    checkOutput("ovl1_b_gnt", 32'(b_if.gnt), 32'h0);
    stepClock();
    checkOutput("ovl1_q", 32'(q), 32'h07);
    checkOutput("ovl1_prio", 32'(prio_b), 32'h1);
    checkOutput("ovl1_cnt", 32'(conflict_cnt), 32'h1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h1F, 8'h1F);
    checkOutput("ovl2_b_gnt", 32'(b_if.gnt), 32'h1);
    checkOutput("ovl2_conflict", 32'(conflict), 32'h0);
    stepClock();
    checkOutput("ovl2_q", 32'(q), 32'h1F);
    checkOutput("ovl2_prio", 32'(prio_b), 32'h1);
    checkOutput("ovl2_cnt", 32'(conflict_cnt), 32'h1);

    // Zero-mask write is granted and leaves q alone.
    applyStimulus(1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    checkOutput("zmask_gnt", 32'(a_if.gnt), 32'h1);
    stepClock();
    checkOutput("zmask_q", 32'(q), 32'h1F);
    checkOutput("zmask_upd", 32'(upd), 32'h0);

    // Reset back to prio A, then 4 held overlapping requests alternate.
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b0;
    stepClock();
    checkOutput("rst2_prio", 32'(prio_b), 32'h0);
    checkOutput("rst2_q", 32'(q), 32'h00);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    stepClock();

    // A FF/3C, B 0F/00: q goes 3C, 30, 3C, 30.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'hFF, 8'h3C, 1'b1, 8'h0F, 8'h00);
      checkOutput($sformatf("alt%0d_a_gnt", k), 32'(a_if.gnt), (k % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("alt%0d_b_gnt", k), 32'(b_if.gnt), (k % 2 == 0) ? 32'h0 : 32'h1);
      stepClock();
      checkOutput($sformatf("alt%0d_q", k), 32'(q), (k % 2 == 0) ? 32'h3C : 32'h30);
    end
    checkOutput("alt_cnt", 32'(conflict_cnt), 32'h4);
    checkOutput("alt_prio", 32'(prio_b), 32'h0);

    // Rewrite of identical data: granted, no change, no pulse.
    applyStimulus(1'b1, 8'hFF, 8'h30, 1'b0, 8'h00, 8'h00);
    checkOutput("same_gnt", 32'(a_if.gnt), 32'h1);
    stepClock();
    checkOutput("same_q", 32'(q), 32'h30);
    checkOutput("same_upd", 32'(upd), 32'h0);

    // 301 more conflicts: 4 + 301 saturates at 255; odd flips leave prio B.
    for (int k = 0; k < 301; k++) begin
      applyStimulus(1'b1, 8'hFF, 8'h3C, 1'b1, 8'h0F, 8'h00);
      stepClock();
    end
    checkOutput("sat_cnt", 32'(conflict_cnt), 32'hFF);
    checkOutput("sat_prio", 32'(prio_b), 32'h1);

    // Reset mid-stall: grants drop immediately, everything clears.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("stall_rst_a_gnt", 32'(a_if.gnt), 32'h0);
    checkOutput("stall_rst_b_gnt", 32'(b_if.gnt), 32'h0);
    stepClock();
    checkOutput("stall_rst_q", 32'(q), 32'h00);
    checkOutput("stall_rst_upd", 32'(upd), 32'h0);
    checkOutput("stall_rst_prio", 32'(prio_b), 32'h0);
    checkOutput("stall_rst_cnt", 32'(conflict_cnt), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
